// File: rtl/div_32_seq.sv
// rtl/div_32_seq.sv - sequential restoring divider, one quotient bit per clock
// Signed mode divides magnitudes and fixes signs up on the final iteration.
module div_32_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic             i_signed,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_quotient,
   output logic [WIDTH-1:0] o_remainder,
   output logic             o_div_by_zero
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvsr_q, dvsr_d;
   logic [WIDTH-1:0] q_out_q, q_out_d;
   logic [WIDTH-1:0] r_out_q, r_out_d;
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] next_rem, next_quo;
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvsr_d  = dvsr_q;
      q_out_d = q_out_q;
      r_out_d = r_out_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      dbz_d   = dbz_q;

      // The quotient register doubles as the dividend shifter feeding rem.
      shifted = {rem_q, quo_q[WIDTH-1]};
      diff    = shifted - {1'b0, dvsr_q};
      if (diff[WIDTH]) begin
         next_rem = shifted[WIDTH-1:0];
         next_quo = {quo_q[WIDTH-2:0], 1'b0};
      end else begin
         next_rem = diff[WIDTH-1:0];
         next_quo = {quo_q[WIDTH-2:0], 1'b1};
      end

      a_neg = i_signed & i_dividend[WIDTH-1];
      b_neg = i_signed & i_divisor[WIDTH-1];
      a_mag = a_neg ? -i_dividend : i_dividend;
      b_mag = b_neg ? -i_divisor : i_divisor;

      case (state_q)
         IDLE: begin
            if (i_start) begin
               if (i_divisor == '0) begin
                  state_d = DONE;
                  q_out_d = '1;
                  r_out_d = i_dividend;
                  dbz_d   = 1'b1;
               end else begin
                  state_d = CALC;
                  cnt_d   = '0;
                  rem_d   = '0;
                  quo_d   = a_mag;
                  dvsr_d  = b_mag;
                  qneg_d  = a_neg ^ b_neg;
                  rneg_d  = a_neg;
                  dbz_d   = 1'b0;
               end
            end
         end
         CALC: begin
            rem_d = next_rem;
            quo_d = next_quo;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               state_d = DONE;
               q_out_d = qneg_q ? -next_quo : next_quo;
               r_out_d = rneg_q ? -next_rem : next_rem;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvsr_q  <= '0;
         q_out_q <= '0;
         r_out_q <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvsr_q  <= dvsr_d;
         q_out_q <= q_out_d;
         r_out_q <= r_out_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         dbz_q   <= dbz_d;
      end
   end

   assign o_busy        = (state_q == CALC);
   assign o_done        = (state_q == DONE);
   assign o_quotient    = q_out_q;
   assign o_remainder   = r_out_q;
   assign o_div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_32_seq.sv
// tb/tb_div_32_seq.sv - self-checking bench for div_32_seq
// Reference results come from native integer division with the special cases spelled out.
module tb_div_32_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_start = 1'b0;
   logic        i_signed = 1'b0;
   logic [31:0] i_dividend = '0;
   logic [31:0] i_divisor = '0;
   logic        o_busy, o_done, o_div_by_zero;
   logic [31:0] o_quotient, o_remainder;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;

   bit          chk_en = 1'b0;
   bit          pend   = 1'b0;
   logic [31:0] p_a, p_b;
   logic        p_sgn;
   int          p_s;

   div_32_seq #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_signed(i_signed),
      .i_dividend(i_dividend), .i_divisor(i_divisor), .o_busy(o_busy),
      .o_done(o_done), .o_quotient(o_quotient), .o_remainder(o_remainder),
      .o_div_by_zero(o_div_by_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        output logic [31:0] q, output logic [31:0] r, output logic dz);
      int sa, sb;
      dz = 1'b0;
      if (b == 0) begin
         q = 32'hFFFF_FFFF; r = a; dz = 1'b1;
      end else if (!sgn) begin
         q = a / b; r = a % b;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000; r = 0;
      end else begin
         sa = a; sb = b;
         q = sa / sb; r = sa % sb;
      end
   endtask

   // Cycle-by-cycle comparison of handshake and results against the model.
   always @(negedge clk) begin
      bit          eb, ed;
      logic [31:0] eq, er, rm, bm;
      logic        edz;
      if (chk_en) begin
         eb = 0; ed = 0; edz = 0; eq = 0; er = 0;
         if (pend) begin
            model(p_a, p_b, p_sgn, eq, er, edz);
            if (edz) ed = (cyc == p_s);
            else begin
               eb = (cyc >= p_s) && (cyc < p_s + 32);
               ed = (cyc == p_s + 32);
            end
         end
         check("busy", {31'b0, o_busy}, {31'b0, eb});
         check("done", {31'b0, o_done}, {31'b0, ed});
         if (ed) begin
            check("quotient", o_quotient, eq);
            check("remainder", o_remainder, er);
            check("div_by_zero", {31'b0, o_div_by_zero}, {31'b0, edz});
            if (!edz) begin
               check("identity", o_quotient * p_b + o_remainder, p_a);
               rm = (p_sgn && o_remainder[31]) ? -o_remainder : o_remainder;
               bm = (p_sgn && p_b[31]) ? -p_b : p_b;
               check("rem_bound", {31'b0, (rm < bm)}, 32'd1);
            end
            pend = 0;
         end
      end
   end

   task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic sgn);
      @(negedge clk);
      i_dividend = a; i_divisor = b; i_signed = sgn; i_start = 1'b1;
      p_a = a; p_b = b; p_sgn = sgn; p_s = cyc + 1; pend = 1;
   endtask

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input bit lit, input logic [31:0] lq, input logic [31:0] lr,
                         input logic ldz, input bit hold);
      bit got;
      got = 0;
      start_op(a, b, sgn);
      for (int t = 0; t < 60; t++) begin
         @(negedge clk);
         if (o_done) begin
            i_start = 1'b0; got = 1; break;
         end
         i_start = hold;
         i_dividend = $urandom;
         i_divisor = hold ? 32'd5 : $urandom;
         i_signed = $urandom_range(0, 1);
      end
      if (!got) begin
         n_assert++; n_fail++; pend = 0;
         $display("FAIL timeout: no o_done for 0x%08h/0x%08h, required within 60 cycles", a, b);
      end else if (lit) begin
         check("lit_quotient", o_quotient, lq);
         check("lit_remainder", o_remainder, lr);
         check("lit_div_by_zero", {31'b0, o_div_by_zero}, {31'b0, ldz});
      end
   endtask

   task automatic do_reset();
      chk_en = 0;
      @(negedge clk);
      rst_n = 1'b0; i_start = 1'b0;
      @(negedge clk);
      check("rst_busy", {31'b0, o_busy}, 32'd0);
      check("rst_done", {31'b0, o_done}, 32'd0);
      check("rst_quotient", o_quotient, 32'd0);
      check("rst_remainder", o_remainder, 32'd0);
      check("rst_div_by_zero", {31'b0, o_div_by_zero}, 32'd0);
      pend = 0; rst_n = 1'b1; chk_en = 1;
   endtask

   initial begin
      logic [31:0] a, b;
      logic        s;
      do_reset();

      run_op(32'd100, 32'd7, 0, 1, 32'd14, 32'd2, 0, 0);
      run_op(32'hFFFF_FFF9, 32'd2, 1, 1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, 0);
      run_op(32'd7, 32'hFFFF_FFFE, 1, 1, 32'hFFFF_FFFD, 32'd1, 0, 0);
      run_op(32'hFFFF_FFFF, 32'h10, 0, 1, 32'h0FFF_FFFF, 32'hF, 0, 0);
      run_op(32'h1234_5678, 32'd0, 0, 1, 32'hFFFF_FFFF, 32'h1234_5678, 1, 0);
      run_op(32'd100, 32'd7, 0, 1, 32'd14, 32'd2, 0, 0);
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1, 1, 32'h8000_0000, 32'd0, 0, 0);
      run_op(32'h8000_0000, 32'd0, 1, 1, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
      run_op(32'd5, 32'd9, 0, 1, 32'd0, 32'd5, 0, 0);
      run_op(32'hDEAD_BEEF, 32'd1, 0, 1, 32'hDEAD_BEEF, 32'd0, 0, 0);
      run_op(32'd100, 32'd7, 0, 1, 32'd14, 32'd2, 0, 1);
      @(negedge clk);
      check("held_quotient", o_quotient, 32'd14);
      check("held_remainder", o_remainder, 32'd2);

      // Abort in the middle of an iteration sequence.
      start_op(32'hCAFE_F00D, 32'd3, 0);
      @(negedge clk);
      i_start = 1'b0;
      repeat (9) @(negedge clk);
      do_reset();
      repeat (40) @(negedge clk);
      run_op(32'd1000, 32'd33, 0, 1, 32'd30, 32'd10, 0, 0);

      for (int i = 0; i < 2000; i++) begin
         s = $urandom_range(0, 1);
         a = ($urandom_range(0, 15) == 0) ? 32'h8000_0000 : $urandom;
         case ($urandom_range(0, 7))
            0:       b = 32'd0;
            1:       b = $urandom_range(1, 16);
            2:       b = 32'hFFFF_FFFF;
            3:       b = $urandom >> $urandom_range(0, 31);
            default: b = $urandom;
         endcase
         run_op(a, b, s, 0, 0, 0, 0, 0);
      end

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
